// File: rtl/cordic_pkg.sv
// Shared constants, encodings and arctangent table for the CORDIC engine.
package cordic_pkg;

   localparam int W        = 16;
   localparam int GUARD    = 2;
   localparam int MAX_ITER = 12;
   localparam int IDX_W    = $clog2(MAX_ITER);

   localparam logic MODE_ROT = 1'b0;
   localparam logic MODE_VEC = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // round(256 * atan(2^-i)) in degrees, Q8.8
   localparam logic [15:0] ATAN_TABLE [0:MAX_ITER-1] = '{
      16'd11520, 16'd6801, 16'd3593, 16'd1824, 16'd916, 16'd458,
      16'd229,   16'd115,  16'd57,   16'd29,   16'd14,  16'd7
   };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational lookup of the micro-rotation angle for a given iteration index.
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int OUT_W = cordic_pkg::W + cordic_pkg::GUARD
) (
   input  logic [IDX_W-1:0] iter,
   output logic [OUT_W-1:0] atan
);

   always_comb begin
      atan = '0;
      for (int k = 0; k < MAX_ITER; k++) begin
         if (iter == IDX_W'(k)) begin
            atan = OUT_W'(ATAN_TABLE[k]);
         end
      end
   end

endmodule

// File: rtl/cordic_iter_engine.sv
// Sequential CORDIC engine: one micro-rotation per clock, N_ITER rotations per operation.
// Gain is not compensated here; results are saturated back to W bits on completion.
module cordic_iter_engine #(
   parameter int W      = cordic_pkg::W,
   parameter int GUARD  = cordic_pkg::GUARD,
   parameter int N_ITER = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic [W-1:0] x_init,
   input  logic [W-1:0] y_init,
   input  logic [W-1:0] z_init,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] x_out,
   output logic [W-1:0] y_out,
   output logic [W-1:0] z_out
);
   import cordic_pkg::*;

   localparam int IW = W + GUARD;
   localparam logic [IDX_W-1:0] LAST_ITER = IDX_W'(N_ITER - 1);
   localparam logic signed [IW-1:0] SAT_MAX = IW'(2 ** (W - 1) - 1);
   localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

   generate
      if ((N_ITER < 1) || (N_ITER > MAX_ITER)) begin : g_bad_iter
         $error("cordic_iter_engine: N_ITER must be in 1..12");
      end
   endgenerate

   state_t state_reg, state_next;
   logic                   mode_reg;
   logic [IDX_W-1:0]       iter_reg;
   logic signed [IW-1:0]   x_reg, y_reg, z_reg;
   logic signed [IW-1:0]   x_next, y_next, z_next;
   logic signed [IW-1:0]   x_sh, y_sh;
   logic [IW-1:0]          atan_val;
   logic                   dir_pos;
   logic                   load;
   logic [W-1:0]           x_out_reg, y_out_reg, z_out_reg;

   function automatic logic [W-1:0] sat(input logic signed [IW-1:0] v);
      if (v > SAT_MAX) begin
         return SAT_MAX[W-1:0];
      end else if (v < SAT_MIN) begin
         return SAT_MIN[W-1:0];
      end
      return v[W-1:0];
   endfunction

   cordic_atan_rom #(.OUT_W(IW)) u_atan_rom (
      .iter (iter_reg),
      .atan (atan_val)
   );

   // A new operation may start from IDLE or directly from the DONE cycle.
   assign load = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN:  if (iter_reg == LAST_ITER) state_next = ST_DONE;
         ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg == ST_RUN);
      done = (state_reg == ST_DONE);
   end

   // Zero counts as positive for z (rotation) and as non-negative for y (vectoring).
   always_comb begin
      dir_pos = (mode_reg == MODE_ROT) ? ~z_reg[IW-1] : y_reg[IW-1];
      x_sh    = x_reg >>> iter_reg;
      y_sh    = y_reg >>> iter_reg;
      if (dir_pos) begin
         x_next = x_reg - y_sh;
         y_next = y_reg + x_sh;
         z_next = z_reg - $signed(atan_val);
      end else begin
         x_next = x_reg + y_sh;
         y_next = y_reg - x_sh;
         z_next = z_reg + $signed(atan_val);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         mode_reg  <= MODE_ROT;
         iter_reg  <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         z_reg     <= '0;
         x_out_reg <= '0;
         y_out_reg <= '0;
         z_out_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (load) begin
            x_reg    <= IW'($signed(x_init));
            y_reg    <= IW'($signed(y_init));
            z_reg    <= IW'($signed(z_init));
            mode_reg <= mode;
            iter_reg <= '0;
         end else if (state_reg == ST_RUN) begin
            x_reg    <= x_next;
            y_reg    <= y_next;
            z_reg    <= z_next;
            iter_reg <= iter_reg + 1'b1;
            if (iter_reg == LAST_ITER) begin
               x_out_reg <= sat(x_next);
               y_out_reg <= sat(y_next);
               z_out_reg <= sat(z_next);
            end
         end
      end
   end

   assign x_out = x_out_reg;
   assign y_out = y_out_reg;
   assign z_out = z_out_reg;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine: vector table, random ops against an integer model,
// and hand-written handshake / back-to-back / reset sequences.
module tb_cordic_iter_engine;

   localparam int N = 6;

   logic        clk = 1'b0;
   logic        rst, start, mode;
   logic [15:0] x_init, y_init, z_init;
   logic        busy, done;
   logic [15:0] x_out, y_out, z_out;

   int total = 0;
   int bad   = 0;

   int atan_deg [12] = '{11520, 6801, 3593, 1824, 916, 458, 229, 115, 57, 29, 14, 7};

   typedef struct {
      bit m;
      int x, y, z;
      int ex, tx, ey, ty, ez, tz;   // tolerance < 0 means no fixed expectation
   } vec_t;

   vec_t vecs [5];

   cordic_iter_engine #(.W(16), .GUARD(2), .N_ITER(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mode   (mode),
      .x_init (x_init),
      .y_init (y_init),
      .z_init (z_init),
      .busy   (busy),
      .done   (done),
      .x_out  (x_out),
      .y_out  (y_out),
      .z_out  (z_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic int s16(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   // floor(v / 2^i)
   function automatic int floor_div_pow2(input int v, input int i);
      int p;
      p = 1 << i;
      if (v >= 0) return v / p;
      return -((-v + p - 1) / p);
   endfunction

   function automatic int wrap18(input int v);
      logic signed [17:0] t;
      t = v[17:0];
      return int'(t);
   endfunction

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic model(input bit m, input int x0, input int y0, input int z0,
                        output int xo, output int yo, output int zo);
      int x, y, z, xn, yn, d;
      x = x0; y = y0; z = z0;
      for (int i = 0; i < N; i++) begin
         if (m) d = (y < 0) ? 1 : -1;
         else   d = (z >= 0) ? 1 : -1;
         xn = wrap18(x - d * floor_div_pow2(y, i));
         yn = wrap18(y + d * floor_div_pow2(x, i));
         z  = wrap18(z - d * atan_deg[i]);
         x  = xn;
         y  = yn;
      end
      xo = sat16(x); yo = sat16(y); zo = sat16(z);
   endtask

   task automatic chk(input string name, input int act, input int exp, input int tol);
      total++;
      if ((act - exp > tol) || (exp - act > tol)) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (+/-%0d)", name, act, exp, tol);
      end
   endtask

   task automatic launch(input bit m, input int x, input int y, input int z);
      @(negedge clk);
      mode   = m;
      x_init = x[15:0];
      y_init = y[15:0];
      z_init = z[15:0];
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Called at the first negedge after the accepting edge; returns on the done cycle.
   task automatic wait_done(input string name, output int lat, output int bcnt);
      lat  = 1;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy) bcnt++;
      end
      if (!done) chk({name, "_timeout"}, 0, 1, 0);
   endtask

   task automatic check_op(input string name, input bit m, input int x, input int y, input int z,
                           input int lat, input int bcnt);
      int ex, ey, ez;
      model(m, x, y, z, ex, ey, ez);
      $display("op %s mode=%0d x=%0d y=%0d z=%0d -> x=%0d y=%0d z=%0d lat=%0d busy=%0d",
               name, m, x, y, z, s16(x_out), s16(y_out), s16(z_out), lat, bcnt);
      chk({name, "_lat"},  lat,  N + 1, 0);
      chk({name, "_busy"}, bcnt, N, 0);
      chk({name, "_x"}, s16(x_out), ex, 0);
      chk({name, "_y"}, s16(y_out), ey, 0);
      chk({name, "_z"}, s16(z_out), ez, 0);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_busy"}, int'(busy), 0, 0);
      chk({name, "_done"}, int'(done), 0, 0);
      chk({name, "_x"}, s16(x_out), 0, 0);
      chk({name, "_y"}, s16(y_out), 0, 0);
      chk({name, "_z"}, s16(z_out), 0, 0);
   endtask

   initial begin
      int lat, bcnt, dcnt;
      bit m;
      int x, y, z;

      vecs[0] = '{1'b0, 155,   0,     7680,   222,   4, 128,  4, 0,     -1};
      vecs[1] = '{1'b1, 256,   256,   0,      596,   6, 0,    4, 11520, 256};
      vecs[2] = '{1'b1, 32767, 32767, 0,      32767, 0, 0,   -1, 0,     -1};
      vecs[3] = '{1'b0, 155,   0,     23040,  0,    -1, 255,  4, 0,     -1};
      vecs[4] = '{1'b0, 155,   0,     -23040, 0,    -1, -255, 4, 0,     -1};

      rst = 1'b1; start = 1'b0; mode = 1'b0;
      x_init = '0; y_init = '0; z_init = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         launch(vecs[v].m, vecs[v].x, vecs[v].y, vecs[v].z);
         wait_done($sformatf("vec%0d", v), lat, bcnt);
         check_op($sformatf("vec%0d", v), vecs[v].m, vecs[v].x, vecs[v].y, vecs[v].z, lat, bcnt);
         if (vecs[v].tx >= 0) chk($sformatf("vec%0d_xspec", v), s16(x_out), vecs[v].ex, vecs[v].tx);
         if (vecs[v].ty >= 0) chk($sformatf("vec%0d_yspec", v), s16(y_out), vecs[v].ey, vecs[v].ty);
         if (vecs[v].tz >= 0) chk($sformatf("vec%0d_zspec", v), s16(z_out), vecs[v].ez, vecs[v].tz);
      end

      for (int r = 0; r < 25; r++) begin
         m = 1'($urandom_range(0, 1));
         if (!m) begin
            x = int'($urandom_range(0, 16000)) - 8000;
            y = int'($urandom_range(0, 16000)) - 8000;
            z = int'($urandom_range(0, 46080)) - 23040;
         end else begin
            x = int'($urandom_range(0, 32000)) - 16000;
            y = int'($urandom_range(0, 32000)) - 16000;
            z = int'($urandom_range(0, 8000)) - 4000;
         end
         launch(m, x, y, z);
         wait_done($sformatf("rnd%0d", r), lat, bcnt);
         check_op($sformatf("rnd%0d", r), m, x, y, z, lat, bcnt);
      end

      // Handshake: start held high; requests during RUN must be dropped.
      @(negedge clk);
      mode = 1'b0; x_init = 16'd155; y_init = 16'd0; z_init = 16'd2560;
      start = 1'b1;
      dcnt = 0;
      for (int c = 0; c < 3 * (N + 1); c++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      $display("op handshake dones=%0d", dcnt);
      chk("handshake_dones", dcnt, 3, 0);
      begin
         int ex, ey, ez;
         model(1'b0, 155, 0, 2560, ex, ey, ez);
         chk("handshake_y", s16(y_out), ey, 0);
         chk("handshake_z", s16(z_out), ez, 0);
      end

      // Back-to-back: second request issued in the DONE cycle.
      launch(1'b0, 155, 0, 7680);
      wait_done("b2b_first", lat, bcnt);
      check_op("b2b_first", 1'b0, 155, 0, 7680, lat, bcnt);
      z_init = 16'hE200;   // -7680
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_done("b2b_second", lat, bcnt);
      check_op("b2b_second", 1'b0, 155, 0, -7680, lat, bcnt);
      chk("b2b_second_yspec", s16(y_out), -128, 4);

      // Reset mid-run, with a start request while reset is asserted.
      launch(1'b1, 300, 200, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_reset_outputs("midrst");
      rst = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      $display("op midrst activity_after_release=%0d", dcnt);
      chk("midrst_no_activity", dcnt, 0, 0);

      launch(1'b1, 300, 200, 0);
      wait_done("after_rst", lat, bcnt);
      check_op("after_rst", 1'b1, 300, 200, 0, lat, bcnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
